bayer_remosaic: RTL and testbench
=================================

BAYER_REMOSAIC -- requirements
Module: bayer_remosaic

Interface
REQ-001 SHALL have parameter BAYER_PATTERN, default 0, CFA phase of row 0 / column 0: 0=BGGR, 1=RGGB, 2=GRBG, 3=GBRG.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n_i, input, 1, reset; asynchronous assert, active-low.
REQ-004 SHALL have port frame_valid_i, input, 1, high for the duration of a frame.
REQ-005 SHALL have port line_valid_i, input, 1, high for the duration of a line.
REQ-006 SHALL have port data_valid_i, input, 1, data_i qualifier.
REQ-007 SHALL have port data_i, input, 120, 4 RGB pixels; pixel k (k=0..3) R/G/B at [119-30k -: 10], [109-30k -: 10], [99-30k -: 10].
REQ-008 SHALL have port output_valid_o, output, 1, output_o qualifier.
REQ-009 SHALL have port output_o, output, 40, 4 RAW10 pixels; pixel k at [39-10k -: 10].
REQ-010 SHALL have port line_valid_o, output, 1, line_valid_i delayed to align with output_o.
REQ-011 SHALL have port protocol_err_o, output, 1, sticky error flag.

Function
REQ-012 SHALL keep FSM states IDLE (frame_valid_i low), WAIT_LINE (frame high, line low), IN_LINE (both high).
REQ-013 SHALL go IDLE->WAIT_LINE on frame_valid_i rising; WAIT_LINE->IN_LINE on line_valid_i rising; IN_LINE->WAIT_LINE on line_valid_i falling; any state->IDLE when frame_valid_i low.
REQ-014 SHALL clear row parity to 0 in IDLE and toggle it on every IN_LINE->WAIT_LINE transition.
REQ-015 SHALL treat pixels 0 and 2 as even columns, pixels 1 and 3 as odd columns (words always 4-pixel aligned).
REQ-016 SHALL select per pixel the single 10-bit channel the CFA site (row parity, column parity, BAYER_PATTERN) dictates; no arithmetic, no rounding.
REQ-017 SHALL for BGGR emit even rows B,G,B,G and odd rows G,R,G,R; other patterns by the same site mapping.
REQ-018 SHALL use 2-cycle latency from data_valid_i to output_valid_o (stage 1 capture, stage 2 select), with line_valid_o delayed 2 cycles.
REQ-019 SHALL accept data_valid_i only in IN_LINE; data_valid_i outside IN_LINE is dropped and sets protocol_err_o.
REQ-020 SHALL clear protocol_err_o on frame_valid_i rising edge; setting wins if both occur in the same cycle.
REQ-021 SHALL complete in-flight words when line_valid_i falls, using the parity latched at capture.
REQ-022 SHALL latch row parity into stage 1 per word so a parity toggle never affects a word already captured.
REQ-023 SHALL hold output_o at its last value while output_valid_o is low.

Reset
REQ-024 SHALL on reset_n_i low force FSM to IDLE, parity to 0, output_valid_o=0, output_o=0, line_valid_o=0, protocol_err_o=0, pipeline valids 0.
REQ-025 SHALL discard any word in flight when reset asserts mid-line; the first word after release is treated as row 0.

Configuration
REQ-026 SHALL compile status counters when macro BAYER_REMOSAIC_COUNT_EN is defined: line_count_o (12 bit, lines completed this frame) and word_count_o (10 bit, words accepted this line), both reset 0, cleared on frame/line start, saturating.
REQ-027 SHALL omit those ports and counters entirely when BAYER_REMOSAIC_COUNT_EN is undefined; all other behaviour identical.

Structure
REQ-028 SHALL place the FSM state enum, CFA pattern codes, and pixel/channel width constants in shared package csi_bridge_pkg.
REQ-029 SHALL instantiate one sub-module bayer_site_select (combinational; one RGB pixel + row/col parity + pattern -> 10-bit sample), four copies.

Verification
REQ-030 BGGR, row 0, data_i pixels R=0x3FF,G=0x200,B=0x001 all -> output_o={0x001,0x200,0x001,0x200}, valid 2 cycles later.
REQ-031 BGGR, second line, same data -> output_o={0x200,0x3FF,0x200,0x3FF}; third line returns to row-0 pattern.
REQ-032 BAYER_PATTERN=1, row 0, same data -> {0x3FF,0x200,0x3FF,0x200}.
REQ-033 data_valid_i pulse with line_valid_i low -> no output_valid_o, protocol_err_o=1 until next frame_valid_i rising.
REQ-034 reset_n_i low mid-line for 1 cycle -> all outputs 0 immediately; next line after new frame emits row-0 pattern.
REQ-035 with BAYER_REMOSAIC_COUNT_EN, 3 lines of 5 words -> line_count_o=3, word_count_o=5 at end of frame.

Source files
------------

// File: rtl/csi_bridge_pkg.sv
// Shared types and constants for the CSI bridge: frame FSM states, CFA pattern
// codes, pixel/channel widths and the CFA site-to-channel mapping.
package csi_bridge_pkg;

  localparam int unsigned PixW   = 10;         // one colour channel / RAW sample
  localparam int unsigned RgbW   = 3 * PixW;   // one RGB pixel
  localparam int unsigned NumPix = 4;          // pixels per bus word

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitLine = 2'd1,
    StInLine   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CfaBggr = 2'd0,
    CfaRggb = 2'd1,
    CfaGrbg = 2'd2,
    CfaGbrg = 2'd3
  } cfa_e;

  typedef enum logic [1:0] {
    ChR = 2'd0,
    ChG = 2'd1,
    ChB = 2'd2
  } chan_e;

  // Channel sampled at a CFA site given the pattern and the row/column parity.
  function automatic chan_e cfa_channel(logic [1:0] pat, logic row, logic col);
    logic green_on_diag;
    logic red_on_row0;
    green_on_diag = (pat == CfaGrbg) || (pat == CfaGbrg);
    red_on_row0   = (pat == CfaRggb) || (pat == CfaGrbg);
    if ((row == col) == green_on_diag) begin
      return ChG;
    end else if (row != red_on_row0) begin
      return ChR;
    end else begin
      return ChB;
    end
  endfunction

endpackage

// File: rtl/bayer_site_select.sv
// Picks the one 10-bit channel of an RGB pixel that its CFA site samples.
module bayer_site_select
  import csi_bridge_pkg::*;
(
  input  logic [RgbW-1:0] rgb_i,
  input  logic            row_par_i,
  input  logic            col_par_i,
  input  logic [1:0]      pattern_i,
  output logic [PixW-1:0] sample_o
);

  chan_e ch;

  // Pure channel mux; no arithmetic on the sample.
  always_comb begin
    ch       = cfa_channel(pattern_i, row_par_i, col_par_i);
    sample_o = rgb_i[PixW-1:0];
    unique case (ch)
      ChR:     sample_o = rgb_i[3*PixW-1 -: PixW];
      ChG:     sample_o = rgb_i[2*PixW-1 -: PixW];
      ChB:     sample_o = rgb_i[PixW-1:0];
      default: sample_o = rgb_i[PixW-1:0];
    endcase
  end

endmodule

// File: rtl/bayer_remosaic.sv
// RGB-to-Bayer remosaic: 4 RGB pixels in, 4 RAW10 samples out, 2-cycle latency.
// Optional status counters are built when BAYER_REMOSAIC_COUNT_EN is defined.
module bayer_remosaic
  import csi_bridge_pkg::*;
#(
  parameter int unsigned BAYER_PATTERN = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   frame_valid_i,
  input  logic                   line_valid_i,
  input  logic                   data_valid_i,
  input  logic [NumPix*RgbW-1:0] data_i,
  output logic                   output_valid_o,
  output logic [NumPix*PixW-1:0] output_o,
  output logic                   line_valid_o,
  output logic                   protocol_err_o
`ifdef BAYER_REMOSAIC_COUNT_EN
  ,
  output logic [11:0]            line_count_o,
  output logic [9:0]             word_count_o
`endif
);

  localparam logic [1:0] Pattern = 2'(BAYER_PATTERN);

  state_e state_q, state_d;
  logic   parity_q, parity_d;
  logic   err_q, err_d;
  logic   accept, frame_rise, line_start, line_end;

  logic                   s1_valid_q;
  logic [NumPix*RgbW-1:0] s1_data_q;
  logic                   s1_parity_q;
  logic [1:0]             lv_q;
  logic                   out_valid_q;
  logic [NumPix*PixW-1:0] out_q;
  logic [NumPix*PixW-1:0] sel;

  // Frame/line FSM next state and control strobes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (frame_valid_i) state_d = StWaitLine;
      StWaitLine: begin
        if (!frame_valid_i)    state_d = StIdle;
        else if (line_valid_i) state_d = StInLine;
      end
      StInLine: begin
        if (!frame_valid_i)     state_d = StIdle;
        else if (!line_valid_i) state_d = StWaitLine;
      end
      default:    state_d = StIdle;
    endcase
    accept     = data_valid_i && (state_q == StInLine);
    frame_rise = (state_q == StIdle) && frame_valid_i;
    line_start = (state_q == StWaitLine) && (state_d == StInLine);
    line_end   = (state_q == StInLine) && (state_d == StWaitLine);
    parity_d   = (state_q == StIdle) ? 1'b0 : (line_end ? ~parity_q : parity_q);
    // A dropped word sets the flag even on the cycle a new frame would clear it.
    err_d      = (data_valid_i && !accept) ? 1'b1 : (frame_rise ? 1'b0 : err_q);
  end

  // FSM, row parity and sticky error flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StIdle;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end

  // Stage 1: capture word with the row parity current at acceptance.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_parity_q <= 1'b0;
      lv_q        <= '0;
    end else begin
      s1_valid_q <= accept;
      lv_q       <= {lv_q[0], line_valid_i};
      if (accept) begin
        s1_data_q   <= data_i;
        s1_parity_q <= parity_q;
      end
    end
  end

  // Pixel k sits in column parity k[0] because words are 4-pixel aligned.
  for (genvar k = 0; k < NumPix; k++) begin : g_site
    bayer_site_select u_site (
      .rgb_i     (s1_data_q[NumPix*RgbW-1-RgbW*k -: RgbW]),
      .row_par_i (s1_parity_q),
      .col_par_i (1'(k % 2)),
      .pattern_i (Pattern),
      .sample_o  (sel[NumPix*PixW-1-PixW*k -: PixW])
    );
  end

  // Stage 2: register selected samples; hold the last word while idle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) out_q <= sel;
    end
  end

  assign output_valid_o = out_valid_q;
  assign output_o       = out_q;
  assign line_valid_o   = lv_q[1];
  assign protocol_err_o = err_q;

`ifdef BAYER_REMOSAIC_COUNT_EN
  logic [11:0] line_cnt_q;
  logic [9:0]  word_cnt_q;

  // Saturating per-frame line count and per-line word count.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      line_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      if (frame_rise)                        line_cnt_q <= '0;
      else if (line_end && line_cnt_q != '1) line_cnt_q <= line_cnt_q + 12'd1;
      if (line_start)                        word_cnt_q <= '0;
      else if (accept && word_cnt_q != '1)   word_cnt_q <= word_cnt_q + 10'd1;
    end
  end

  assign line_count_o = line_cnt_q;
  assign word_count_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_bayer_remosaic.sv
// Directed self-checking bench for bayer_remosaic (BGGR and RGGB instances).
module tb_bayer_remosaic;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         frame_valid = 1'b0;
  logic         line_valid = 1'b0;
  logic         data_valid = 1'b0;
  logic [119:0] data = '0;

  logic         ov0, lv0, err0, ov1, lv1, err1;
  logic [39:0]  out0, out1;
`ifdef BAYER_REMOSAIC_COUNT_EN
  logic [11:0]  lc0, lc1;
  logic [9:0]   wc0, wc1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [119:0] Word = {4{10'h3FF, 10'h200, 10'h001}};

  always #5 clk = ~clk;

  bayer_remosaic #(.BAYER_PATTERN(0)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .frame_valid_i(frame_valid),
    .line_valid_i(line_valid), .data_valid_i(data_valid), .data_i(data),
    .output_valid_o(ov0), .output_o(out0), .line_valid_o(lv0), .protocol_err_o(err0)
`ifdef BAYER_REMOSAIC_COUNT_EN
    , .line_count_o(lc0), .word_count_o(wc0)
`endif
  );

  bayer_remosaic #(.BAYER_PATTERN(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .frame_valid_i(frame_valid),
    .line_valid_i(line_valid), .data_valid_i(data_valid), .data_i(data),
    .output_valid_o(ov1), .output_o(out1), .line_valid_o(lv1), .protocol_err_o(err1)
`ifdef BAYER_REMOSAIC_COUNT_EN
    , .line_count_o(lc1), .word_count_o(wc1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_valid = 1'b1; tick(); tick();
  endtask

  task automatic end_frame();
    frame_valid = 1'b0; tick(); tick();
  endtask

  task automatic start_line();
    line_valid = 1'b1; tick(); tick();
  endtask

  task automatic end_line();
    line_valid = 1'b0; tick(); tick();
  endtask

  // Word i: pixel k has R=0x100+16i+k, G=0x200+16i+k, B=0x300+16i+k.
  function automatic logic [119:0] mk_word(int i);
    logic [119:0] w;
    for (int k = 0; k < 4; k++) begin
      w[119-30*k -: 10] = 10'(32'h100 + 16 * i + k);
      w[109-30*k -: 10] = 10'(32'h200 + 16 * i + k);
      w[99-30*k -: 10]  = 10'(32'h300 + 16 * i + k);
    end
    return w;
  endfunction

  // BGGR row 0 expectation: B,G,B,G.
  function automatic logic [39:0] exp_bggr_row0(int i);
    return {10'(32'h300 + 16 * i), 10'(32'h201 + 16 * i),
            10'(32'h302 + 16 * i), 10'(32'h203 + 16 * i)};
  endfunction

  task automatic test_reset();
    #1;
    n_checks++;
    if ({ov0, out0, lv0, err0} !== 43'd0) begin
      n_errors++; $display("FAIL reset_outputs got ov=%b out=%h lv=%b err=%b want all 0",
                           ov0, out0, lv0, err0);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_bggr_rows();
    start_frame();
    start_line();
    data = Word; data_valid = 1'b1; tick(); data_valid = 1'b0;
    n_checks++;
    if (ov0 !== 1'b0) begin
      n_errors++; $display("FAIL latency_early got valid=%b want 0", ov0);
    end
    tick();
    n_checks++;
    if (ov0 !== 1'b1 || out0 !== {10'h001, 10'h200, 10'h001, 10'h200}) begin
      n_errors++; $display("FAIL bggr_row0 got valid=%b out=%h want 1 %h", ov0, out0,
                           {10'h001, 10'h200, 10'h001, 10'h200});
    end
    n_checks++;
    if (lv0 !== 1'b1) begin
      n_errors++; $display("FAIL line_valid_o got %b want 1", lv0);
    end
    data = '0; tick();
    n_checks++;
    if (ov0 !== 1'b0 || out0 !== {10'h001, 10'h200, 10'h001, 10'h200}) begin
      n_errors++; $display("FAIL output_hold got valid=%b out=%h want 0 held", ov0, out0);
    end
    line_valid = 1'b0; tick();
    n_checks++;
    if (lv0 !== 1'b1) begin
      n_errors++; $display("FAIL line_valid_delay got %b want 1 one cycle after fall", lv0);
    end
    tick();
    // Second line: odd row.
    start_line();
    data = Word; data_valid = 1'b1; tick(); data_valid = 1'b0; tick();
    n_checks++;
    if (ov0 !== 1'b1 || out0 !== {10'h200, 10'h3FF, 10'h200, 10'h3FF}) begin
      n_errors++; $display("FAIL bggr_row1 got valid=%b out=%h want 1 %h", ov0, out0,
                           {10'h200, 10'h3FF, 10'h200, 10'h3FF});
    end
    end_line();
    // Third line: back to row 0.
    start_line();
    data = Word; data_valid = 1'b1; tick(); data_valid = 1'b0; tick();
    n_checks++;
    if (ov0 !== 1'b1 || out0 !== {10'h001, 10'h200, 10'h001, 10'h200}) begin
      n_errors++; $display("FAIL bggr_row2 got valid=%b out=%h want row0 pattern", ov0, out0);
    end
    end_line();
    end_frame();
  endtask

  task automatic test_pattern_rggb();
    start_frame();
    start_line();
    data = Word; data_valid = 1'b1; tick(); data_valid = 1'b0; tick();
    n_checks++;
    if (ov1 !== 1'b1 || out1 !== {10'h3FF, 10'h200, 10'h3FF, 10'h200}) begin
      n_errors++; $display("FAIL rggb_row0 got valid=%b out=%h want 1 %h", ov1, out1,
                           {10'h3FF, 10'h200, 10'h3FF, 10'h200});
    end
    end_line();
    start_line();
    data = Word; data_valid = 1'b1; tick(); data_valid = 1'b0; tick();
    n_checks++;
    if (out1 !== {10'h200, 10'h001, 10'h200, 10'h001}) begin
      n_errors++; $display("FAIL rggb_row1 got out=%h want %h", out1,
                           {10'h200, 10'h001, 10'h200, 10'h001});
    end
    end_line();
    end_frame();
  endtask

  task automatic test_back_to_back();
    start_frame();
    start_line();
    for (int i = 0; i < 5; i++) begin
      data = mk_word(i); data_valid = 1'b1; tick();
      if (i > 0) begin
        n_checks++;
        if (ov0 !== 1'b1 || out0 !== exp_bggr_row0(i - 1)) begin
          n_errors++; $display("FAIL b2b_word%0d got valid=%b out=%h want 1 %h", i - 1, ov0,
                               out0, exp_bggr_row0(i - 1));
        end
      end
    end
    data_valid = 1'b0; tick();
    n_checks++;
    if (ov0 !== 1'b1 || out0 !== exp_bggr_row0(4)) begin
      n_errors++; $display("FAIL b2b_word4 got valid=%b out=%h want 1 %h", ov0, out0,
                           exp_bggr_row0(4));
    end
    end_line();
    end_frame();
  endtask

  task automatic test_protocol_err();
    start_frame();
    data = Word; data_valid = 1'b1; tick(); data_valid = 1'b0;
    n_checks++;
    if (err0 !== 1'b1) begin
      n_errors++; $display("FAIL err_set got %b want 1", err0);
    end
    tick(); tick();
    n_checks++;
    if (ov0 !== 1'b0) begin
      n_errors++; $display("FAIL err_dropped got valid=%b want 0", ov0);
    end
    end_frame();
    n_checks++;
    if (err0 !== 1'b1) begin
      n_errors++; $display("FAIL err_sticky got %b want 1", err0);
    end
    // New frame and stray data on the same cycle: set wins.
    frame_valid = 1'b1; data_valid = 1'b1; tick(); data_valid = 1'b0;
    n_checks++;
    if (err0 !== 1'b1) begin
      n_errors++; $display("FAIL err_set_wins got %b want 1", err0);
    end
    end_frame();
    frame_valid = 1'b1; tick();
    n_checks++;
    if (err0 !== 1'b0) begin
      n_errors++; $display("FAIL err_clear got %b want 0", err0);
    end
    tick();
    end_frame();
  endtask

  task automatic test_reset_mid_line();
    start_frame();
    start_line();
    end_line();
    start_line();
    data = Word; data_valid = 1'b1; tick(); data_valid = 1'b0;
    reset_n = 1'b0; #1;
    n_checks++;
    if ({ov0, out0, lv0, err0} !== 43'd0) begin
      n_errors++; $display("FAIL async_reset got ov=%b out=%h lv=%b err=%b want all 0",
                           ov0, out0, lv0, err0);
    end
    frame_valid = 1'b0; line_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (ov0 !== 1'b0) begin
      n_errors++; $display("FAIL reset_discard got valid=%b want 0", ov0);
    end
    start_frame();
    start_line();
    data = Word; data_valid = 1'b1; tick(); data_valid = 1'b0; tick();
    n_checks++;
    if (ov0 !== 1'b1 || out0 !== {10'h001, 10'h200, 10'h001, 10'h200}) begin
      n_errors++; $display("FAIL post_reset_row0 got valid=%b out=%h want row0 pattern",
                           ov0, out0);
    end
    end_line();
    end_frame();
  endtask

`ifdef BAYER_REMOSAIC_COUNT_EN
  task automatic test_counters();
    start_frame();
    for (int l = 0; l < 3; l++) begin
      start_line();
      for (int i = 0; i < 5; i++) begin
        data = mk_word(i); data_valid = 1'b1; tick();
      end
      data_valid = 1'b0; tick();
      end_line();
    end
    n_checks++;
    if (lc0 !== 12'd3 || wc0 !== 10'd5) begin
      n_errors++; $display("FAIL counters got lines=%0d words=%0d want 3 5", lc0, wc0);
    end
    end_frame();
  endtask
`endif

  initial begin
    test_reset();
    test_bggr_rows();
    test_pattern_rggb();
    test_back_to_back();
    test_protocol_err();
    test_reset_mid_line();
`ifdef BAYER_REMOSAIC_COUNT_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
